baud_tick_gen: RTL and testbench

// - Parametrised UART timing generator. Produces single-cycle enable ticks, not a derived clock.
//   - tick_os: oversample tick for the RX sampler.
//   - tick_bit: bit tick for the TX shifter.
//   - baud_clk: 50% square wave for legacy consumers.
// - Rate comes from a 4-entry preset table (baud_sel) or a runtime custom divisor.
// - Sits between the system clock domain and the UART TX/RX engines; all outputs are synchronous to clk.

---
 rtl/baud_tick_gen_if.sv | 37 +++
 rtl/baud_tick_gen.sv | 165 ++++++++++++++++
 tb/tb_baud_tick_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - configuration inputs and tick outputs of baud_tick_gen (cfg_frac only with FRAC_DIV_EN)
interface baud_tick_gen_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic [1:0]       baud_sel;
    logic             sel_custom;
    logic [DIV_W-1:0] cfg_div;
`ifdef FRAC_DIV_EN
    logic [3:0]       cfg_frac;
`endif
    logic             tick_os;
    logic             tick_bit;
    logic             baud_clk;

`ifdef FRAC_DIV_EN
    modport master (
        output en, baud_sel, sel_custom, cfg_div, cfg_frac,
        input  tick_os, tick_bit, baud_clk
    );

    modport slave (
        input  en, baud_sel, sel_custom, cfg_div, cfg_frac,
        output tick_os, tick_bit, baud_clk
    );
`else
    modport master (
        output en, baud_sel, sel_custom, cfg_div,
        input  tick_os, tick_bit, baud_clk
    );

    modport slave (
        input  en, baud_sel, sel_custom, cfg_div,
        output tick_os, tick_bit, baud_clk
    );
`endif
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - UART oversample/bit tick and baud clock generator
// Optional fractional divisor with FRAC_DIV_EN.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    baud_tick_gen_if.slave bus
);
    localparam int               BIT_W    = $clog2(OVERSAMPLE);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(OVERSAMPLE / 2);

    // Presets are 50 MHz values and need at least 9 divisor bits to hold 326.
    if (CLK_FREQ <= 0 || OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0 || DIV_W < 9) begin : g_bad_param
        $error("baud_tick_gen: unsupported parameter set");
    end

    function automatic logic [DIV_W-1:0] preset_div(input logic [1:0] sel);
        case (sel)
`ifdef FRAC_DIV_EN
            2'b00:   return DIV_W'(325);
            2'b01:   return DIV_W'(162);
            2'b10:   return DIV_W'(81);
            default: return DIV_W'(54);
`else
            2'b00:   return DIV_W'(326);
            2'b01:   return DIV_W'(163);
            2'b10:   return DIV_W'(81);
            default: return DIV_W'(54);
`endif
        endcase
    endfunction

`ifdef FRAC_DIV_EN
    function automatic logic [3:0] preset_frac(input logic [1:0] sel);
        case (sel)
            2'b00:   return 4'd8;
            2'b01:   return 4'd12;
            2'b10:   return 4'd6;
            default: return 4'd4;
        endcase
    endfunction
`endif

    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] new_div;
    logic [DIV_W-1:0] os_cnt;
    logic [DIV_W-1:0] os_last;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [1:0]       sel_q;
    logic             custom_q;
    logic             cfg_change;
    logic             os_wrap;
    logic             tick_os_q;
    logic             tick_bit_q;
    logic             baud_clk_q;
`ifdef FRAC_DIV_EN
    logic [3:0]       cur_frac;
    logic [3:0]       new_frac;
    logic [3:0]       frac_q;
    logic [3:0]       acc;
    logic [3:0]       acc_sum;
    logic             acc_carry;
    logic             ext;
`endif

    always_comb begin
        new_div    = preset_div(bus.baud_sel);
        cfg_change = (bus.baud_sel != sel_q) || (bus.sel_custom != custom_q);
        if (bus.sel_custom) begin
            new_div    = (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
            cfg_change = cfg_change || (bus.cfg_div != div_q);
        end
`ifdef FRAC_DIV_EN
        new_frac   = bus.sel_custom ? bus.cfg_frac : preset_frac(bus.baud_sel);
        cfg_change = cfg_change || (bus.cfg_frac != frac_q);
        {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, cur_frac};
        // A carry on the previous tick stretches the current period by one cycle.
        os_last    = cur_div - DIV_W'(1) + DIV_W'(ext);
`else
        os_last    = cur_div - DIV_W'(1);
`endif
        os_wrap    = bus.en && (os_cnt == os_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_div    <= preset_div(2'b00);
            os_cnt     <= '0;
            bit_cnt    <= '0;
            sel_q      <= 2'b00;
            custom_q   <= 1'b0;
            div_q      <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
            baud_clk_q <= 1'b0;
`ifdef FRAC_DIV_EN
            cur_frac   <= preset_frac(2'b00);
            frac_q     <= 4'd0;
            acc        <= 4'd0;
            ext        <= 1'b0;
`endif
        end else begin
            sel_q    <= bus.baud_sel;
            custom_q <= bus.sel_custom;
            div_q    <= bus.cfg_div;
`ifdef FRAC_DIV_EN
            frac_q   <= bus.cfg_frac;
`endif
            // Reload takes priority over a coinciding wrap: the old period is dropped without a tick.
            if (cfg_change) begin
                cur_div    <= new_div;
                os_cnt     <= '0;
                bit_cnt    <= '0;
                tick_os_q  <= 1'b0;
                tick_bit_q <= 1'b0;
                baud_clk_q <= 1'b0;
`ifdef FRAC_DIV_EN
                cur_frac   <= new_frac;
                acc        <= 4'd0;
                ext        <= 1'b0;
`endif
            end else if (!bus.en) begin
                os_cnt     <= '0;
                bit_cnt    <= '0;
                tick_os_q  <= 1'b0;
                tick_bit_q <= 1'b0;
                baud_clk_q <= 1'b0;
`ifdef FRAC_DIV_EN
                acc        <= 4'd0;
                ext        <= 1'b0;
`endif
            end else begin
                tick_os_q  <= os_wrap;
                tick_bit_q <= os_wrap && (bit_cnt == BIT_LAST);
                if (os_wrap) begin
                    os_cnt <= '0;
`ifdef FRAC_DIV_EN
                    acc    <= acc_sum;
                    ext    <= acc_carry;
`endif
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt    <= '0;
                        baud_clk_q <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt + BIT_W'(1) == BIT_HALF) begin
                            baud_clk_q <= 1'b1;
                        end
                    end
                end else begin
                    os_cnt <= os_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign bus.tick_os  = tick_os_q;
    assign bus.tick_bit = tick_bit_q;
    assign bus.baud_clk = baud_clk_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - self-checking bench for baud_tick_gen (default integer build)
`timescale 1ns/1ps
module tb_baud_tick_gen;
    localparam int OS = 16;

    typedef struct {
        int   cyc;
        logic tb;
        logic bc;
    } tick_t;

    logic  clk = 1'b0;
    logic  rst;
    int    cyc = 0;
    int    hi_cnt = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    tick_t exp_q[$];
    tick_t obs_q[$];

    baud_tick_gen_if #(.DIV_W(16)) bus ();

    baud_tick_gen #(
        .CLK_FREQ  (50_000_000),
        .OVERSAMPLE(OS),
        .DIV_W     (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with tick_os high is recorded with the cycle number of the preceding edge.
    always @(negedge clk) begin
        tick_t t;
        if (bus.baud_clk === 1'b1) hi_cnt <= hi_cnt + 1;
        if (bus.tick_os !== 1'b0) begin
            t.cyc = cyc;
            t.tb  = bus.tick_bit;
            t.bc  = bus.baud_clk;
            obs_q.push_back(t);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_ticks(input int base, input int d, input int k0, input int k1);
        tick_t t;
        for (int k = k0; k <= k1; k++) begin
            t.cyc = base + k * d;
            t.tb  = ((k % OS) == 0);
            t.bc  = ((k % OS) >= OS / 2);
            exp_q.push_back(t);
        end
    endtask

    task automatic check_events(input string tag);
        tick_t e;
        tick_t o;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_cyc"}, o.cyc, e.cyc);
            check({tag, "_tick_bit"}, o.tb, e.tb);
            check({tag, "_baud_clk"}, o.bc, e.bc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int c1, c2, r, c3, c4, c6, c7, c8, hs;
        rst            = 1'b0;
        bus.en         = 1'b0;
        bus.baud_sel   = 2'b00;
        bus.sel_custom = 1'b0;
        bus.cfg_div    = '0;
        step();
        step();
        check("rst_tick_os", bus.tick_os, 0);
        check("rst_tick_bit", bus.tick_bit, 0);
        check("rst_baud_clk", bus.baud_clk, 0);

        rst = 1'b1;
        repeat (20) step();
        check_events("idle");

        // Preset 00: D=326, bit period 5216, baud_clk high for the second half-bit.
        c1     = cyc;
        hs     = hi_cnt;
        bus.en = 1'b1;
        push_ticks(c1, 326, 1, 32);
        wait_until(c1 + 32 * 326);
        check("p00_baud_hi", hi_cnt - hs, 16 * 326);
        check_events("p00");

        push_ticks(c1, 326, 33, 41);
        wait_until(c1 + 41 * 326 + 100);
        check("pre_switch_baud_clk", bus.baud_clk, 1);
        check_events("p00b");

        // Mid-bit switch to preset 11 (D=54).
        c2           = cyc;
        bus.baud_sel = 2'b11;
        step();
        check("reload_tick_os", bus.tick_os, 0);
        check("reload_baud_clk", bus.baud_clk, 0);
        r = c2 + 1;
        push_ticks(r, 54, 1, 16);
        wait_until(r + 17 * 54 - 1);
        check_events("p11");

        // Config change lands on the same edge as a wrap: no tick.
        c3             = cyc;
        bus.sel_custom = 1'b1;
        bus.cfg_div    = 16'd4;
        step();
        check("wrap_reload_tick_os", bus.tick_os, 0);
        push_ticks(c3 + 1, 4, 1, 32);
        wait_until(c3 + 1 + 32 * 4);
        check_events("div4");

        // cfg_div=0 behaves as D=1.
        c4          = cyc;
        bus.cfg_div = '0;
        step();
        check("div0_reload_tick_os", bus.tick_os, 0);
        push_ticks(c4 + 1, 1, 1, 40);
        wait_until(c4 + 1 + 40);

        // Asynchronous reset between edges while tick_os and baud_clk are high.
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_tick_os", bus.tick_os, 0);
        check("async_rst_tick_bit", bus.tick_bit, 0);
        check("async_rst_baud_clk", bus.baud_clk, 0);
        check_events("div1");

        bus.sel_custom = 1'b0;
        bus.baud_sel   = 2'b00;
        bus.cfg_div    = '0;
        repeat (3) step();
        check("hold_rst_tick_os", bus.tick_os, 0);
        check("hold_rst_baud_clk", bus.baud_clk, 0);
        c6  = cyc;
        rst = 1'b1;
        push_ticks(c6, 326, 1, 9);
        wait_until(c6 + 9 * 326 + 20);
        check("pre_dis_baud_clk", bus.baud_clk, 1);
        check_events("rel");

        // en=0 for 100 cycles, then re-enable.
        c7     = cyc;
        bus.en = 1'b0;
        step();
        check("dis_baud_clk", bus.baud_clk, 0);
        check("dis_tick_os", bus.tick_os, 0);
        hs = hi_cnt;
        wait_until(c7 + 100);
        check("dis_baud_hi", hi_cnt - hs, 0);
        check_events("dis");

        c8     = cyc;
        bus.en = 1'b1;
        push_ticks(c8, 326, 1, 2);
        wait_until(c8 + 2 * 326);
        check_events("reen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
